// File: rtl/reg_cdc_hs_rx_pkg.sv
// reg_cdc_hs_rx_pkg: state encoding and settle-counter sizing shared by the CDC handshake receiver.
package reg_cdc_hs_rx_pkg;
    typedef enum logic [1:0] {IDLE, SETTLE, PRESENT, WAIT_LOW} state_t;
    localparam int SETTLE_W = 4;
endpackage

// File: rtl/reg_cdc_hs_rx.sv
// reg_cdc_hs_rx: destination side of a 4-phase req/ack crossing; waits for data_in to settle, presents it on valid/ready, then acks.
module reg_cdc_hs_rx
    import reg_cdc_hs_rx_pkg::*;
#(
    parameter int DATA_W        = 32,
    parameter int SETTLE_CYCLES = 2,
    parameter int CNT_W         = 16
) (
    input  logic              dst_clk,
    input  logic              dst_rst,
    input  logic              req_in,
    input  logic [DATA_W-1:0] data_in,
    output logic              ack_out,
    output logic [DATA_W-1:0] out_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CNT_W-1:0]  xfer_count,
    output logic              proto_err
);
    state_t              state;
    logic [SETTLE_W-1:0] cnt;
    always_ff @(posedge dst_clk) begin
        if (dst_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            ack_out    <= 1'b0;
            out_data   <= '0;
            out_valid  <= 1'b0;
            xfer_count <= '0;
            proto_err  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    ack_out <= 1'b0;
                    if (req_in) begin
                        state <= SETTLE;
                        cnt   <= '0;
                    end
                end
                SETTLE: begin
                    // a request that drops before capture is a glitch or an early release
                    if (!req_in) begin
                        proto_err <= 1'b1;
                        state     <= IDLE;
                    end else if (cnt == SETTLE_W'(SETTLE_CYCLES - 1)) begin
                        out_data  <= data_in;
                        out_valid <= 1'b1;
                        state     <= PRESENT;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                PRESENT: begin
                    if (!req_in) proto_err <= 1'b1;
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        ack_out   <= 1'b1;
                        state     <= WAIT_LOW;
                    end
                end
                WAIT_LOW: begin
                    if (!req_in) begin
                        ack_out    <= 1'b0;
                        xfer_count <= xfer_count + 1'b1;
                        state      <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule
